// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter.
// A grant is held until its requester drops req, or until the hold timeout
// forces it off. Every release is followed by one idle turnaround cycle.
// grant_id / grant_valid follow the shared 4-to-2 encoder output convention.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       grant_valid,
   output logic       preempt
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
   localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);

   state_e           state_q;
   logic [1:0]       last_id_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [3:0]       grant_q;
   logic [1:0]       grant_id_q;
   logic             grant_valid_q;
   logic             preempt_q;

   logic [2:0]       pick_s;      // {found, index}
   logic             hold_hit_s;

   // Round-robin search: first set bit of r starting at (last+1) mod 4.
   // Offsets are scanned farthest-first so the nearest hit overwrites.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int o = 4; o >= 1; o--) begin
         idx = last + 2'(o);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Next winner among the current requests, relative to the last holder.
   always_comb begin
      pick_s = rr_pick(req, last_id_q);
   end

   // Timeout condition: holder has already used its full hold budget.
   always_comb begin
      hold_hit_s = 1'b0;
      if (TIMEOUT_EN && (hold_cnt_q == HOLD_LIMIT)) begin
         hold_hit_s = 1'b1;
      end else begin
         hold_hit_s = 1'b0;
      end
   end

   // Arbiter FSM with registered grant outputs and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_id_q     <= 2'b11;
         hold_cnt_q    <= '0;
         grant_q       <= 4'b0000;
         grant_id_q    <= 2'b00;
         grant_valid_q <= 1'b0;
         preempt_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               preempt_q <= 1'b0;
               if (pick_s[2]) begin
                  state_q       <= ST_GRANT;
                  grant_q       <= 4'b0001 << pick_s[1:0];
                  grant_id_q    <= pick_s[1:0];
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= CNT_W'(1);
               end else begin
                  grant_q       <= 4'b0000;
                  grant_id_q    <= 2'b00;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= '0;
               end
            end
            ST_GRANT: begin
               if (!req[grant_id_q]) begin
                  // voluntary release
                  state_q       <= ST_IDLE;
                  last_id_q     <= grant_id_q;
                  grant_q       <= 4'b0000;
                  grant_id_q    <= 2'b00;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= '0;
                  preempt_q     <= 1'b0;
               end else if (hold_hit_s) begin
                  // forced release; holder drops to lowest priority
                  state_q       <= ST_IDLE;
                  last_id_q     <= grant_id_q;
                  grant_q       <= 4'b0000;
                  grant_id_q    <= 2'b00;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= '0;
                  preempt_q     <= 1'b1;
               end else begin
                  preempt_q <= 1'b0;
                  if (hold_cnt_q != CNT_SAT) begin
                     hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                  end else begin
                     hold_cnt_q <= CNT_SAT;
                  end
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               last_id_q     <= 2'b11;
               hold_cnt_q    <= '0;
               grant_q       <= 4'b0000;
               grant_id_q    <= 2'b00;
               grant_valid_q <= 1'b0;
               preempt_q     <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;
   assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (MAX_HOLD = 16, 4, 0) checked
// cycle by cycle against a behavioural round-robin reference model.
module tb_rr_arbiter4;

   localparam int MH [3] = '{16, 4, 0};

   typedef struct packed {
      logic        valid;
      logic        pre;
      logic [1:0]  id;
      logic [1:0]  last;
      logic [31:0] held;
   } mstate_t;

   logic       clk = 1'b0;
   logic       rst_n_v [3];
   logic [3:0] req_v   [3];
   logic [3:0] gnt     [3];
   logic [1:0] gid     [3];
   logic       gv      [3];
   logic       pe      [3];

   mstate_t m [3];
   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   rr_arbiter4 #(.MAX_HOLD(16), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]),
      .grant(gnt[0]), .grant_id(gid[0]), .grant_valid(gv[0]), .preempt(pe[0]));
   rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]),
      .grant(gnt[1]), .grant_id(gid[1]), .grant_valid(gv[1]), .preempt(pe[1]));
   rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n_v[2]), .req(req_v[2]),
      .grant(gnt[2]), .grant_id(gid[2]), .grant_valid(gv[2]), .preempt(pe[2]));

   // Reference model: state after one clock edge given requests and reset.
   function automatic mstate_t model_next(input mstate_t s, input logic [3:0] r,
                                          input logic rst, input int mh);
      mstate_t n;
      int idx;
      n = s;
      if (!rst) begin
         n.valid = 1'b0; n.pre = 1'b0; n.id = 2'd0; n.last = 2'd3; n.held = 32'd0;
      end else if (!s.valid) begin
         n.pre = 1'b0;
         for (int o = 1; o <= 4; o++) begin
            idx = (int'(s.last) + o) % 4;
            if (!n.valid && r[idx]) begin
               n.valid = 1'b1; n.id = 2'(idx); n.held = 32'd1;
            end
         end
      end else if (!r[s.id]) begin
         n.valid = 1'b0; n.last = s.id; n.id = 2'd0; n.held = 32'd0;
      end else if (mh != 0 && s.held == 32'(mh)) begin
         n.valid = 1'b0; n.last = s.id; n.id = 2'd0; n.pre = 1'b1; n.held = 32'd0;
      end else begin
         n.held = s.held + 32'd1;
      end
      return n;
   endfunction

   // Advance the reference model of every instance on each rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         m[k] <= model_next(m[k], req_v[k], rst_n_v[k], MH[k]);
      end
   end

   function automatic logic [7:0] exp_out(input int k);
      logic [3:0] g;
      g = m[k].valid ? (4'b0001 << m[k].id) : 4'b0000;
      return {g, m[k].id, m[k].valid, m[k].pre};
   endfunction

   function automatic logic [7:0] act_out(input int k);
      return {gnt[k], gid[k], gv[k], pe[k]};
   endfunction

   task automatic reset_all();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         rst_n_v[k] = 1'b0;
         req_v[k]   = 4'b0000;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) rst_n_v[k] = 1'b1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst_n_v[k] = 1'b0;
         req_v[k]   = 4'b0000;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act_out(k) !== 8'h00) $display("FAIL reset inst%0d: got %b want %b", k, act_out(k), 8'h00);
         else pass_cnt++;
      end
      for (int k = 0; k < 3; k++) rst_n_v[k] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act_out(k) !== 8'h00) $display("FAIL idle_after_reset inst%0d: got %b want %b", k, act_out(k), 8'h00);
         else pass_cnt++;
      end
   endtask

   task automatic test_rotation();
      int starts[$];
      int npre;
      logic prev_v;
      int want [5] = '{0, 1, 2, 3, 0};
      npre = 0; prev_v = 1'b0;
      reset_all();
      req_v[0] = 4'b1111;
      for (int c = 1; c <= 71; c++) begin
         @(negedge clk);
         total_cnt++;
         if (act_out(0) !== exp_out(0)) $display("FAIL rotation cyc%0d: got %b want %b", c, act_out(0), exp_out(0));
         else pass_cnt++;
         if (gv[0] && !prev_v) starts.push_back(int'(gid[0]));
         if (pe[0]) npre++;
         prev_v = gv[0];
      end
      total_cnt++;
      if (starts.size() != 5) $display("FAIL rotation_count: got %0d want %0d", starts.size(), 5);
      else pass_cnt++;
      for (int i = 0; i < 5 && i < starts.size(); i++) begin
         total_cnt++;
         if (starts[i] != want[i]) $display("FAIL rotation_order[%0d]: got %0d want %0d", i, starts[i], want[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (npre != 4) $display("FAIL rotation_preempts: got %0d want %0d", npre, 4);
      else pass_cnt++;
   endtask

   task automatic test_release();
      int nvalid;
      int npre;
      nvalid = 0; npre = 0;
      reset_all();
      req_v[0] = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         total_cnt++;
         if (act_out(0) !== exp_out(0)) $display("FAIL release cyc%0d: got %b want %b", c, act_out(0), exp_out(0));
         else pass_cnt++;
         if (gv[0]) begin
            nvalid++;
            total_cnt++;
            if (gnt[0] !== 4'b0100 || gid[0] !== 2'd2) $display("FAIL release_holder: got %b/%0d want 0100/2", gnt[0], gid[0]);
            else pass_cnt++;
         end
         if (pe[0]) npre++;
         if (c == 3) req_v[0] = 4'b0000;
      end
      total_cnt++;
      if (nvalid != 3 || npre != 0) $display("FAIL release_len: got valid=%0d pre=%0d want valid=3 pre=0", nvalid, npre);
      else pass_cnt++;
      total_cnt++;
      if (act_out(0) !== 8'h00) $display("FAIL release_idle: got %b want %b", act_out(0), 8'h00);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int starts[$];
      logic prev_v;
      int want [3] = '{1, 3, 0};
      prev_v = 1'b0;
      reset_all();
      for (int e = 1; e <= 9; e++) begin
         if (e <= 2)      req_v[0] = 4'b0010;
         else if (e <= 5) req_v[0] = 4'b1001;
         else if (e <= 7) req_v[0] = 4'b0001;
         else             req_v[0] = 4'b0000;
         @(negedge clk);
         total_cnt++;
         if (act_out(0) !== exp_out(0)) $display("FAIL wrap cyc%0d: got %b want %b", e, act_out(0), exp_out(0));
         else pass_cnt++;
         if (gv[0] && !prev_v) starts.push_back(int'(gid[0]));
         prev_v = gv[0];
      end
      total_cnt++;
      if (starts.size() != 3) $display("FAIL wrap_count: got %0d want %0d", starts.size(), 3);
      else pass_cnt++;
      for (int i = 0; i < 3 && i < starts.size(); i++) begin
         total_cnt++;
         if (starts[i] != want[i]) $display("FAIL wrap_order[%0d]: got %0d want %0d", i, starts[i], want[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_sole_timeout();
      int npre;
      int nvalid;
      npre = 0; nvalid = 0;
      reset_all();
      req_v[1] = 4'b0100;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         total_cnt++;
         if (act_out(1) !== exp_out(1)) $display("FAIL sole cyc%0d: got %b want %b", c, act_out(1), exp_out(1));
         else pass_cnt++;
         if (pe[1]) npre++;
         if (gv[1]) nvalid++;
      end
      total_cnt++;
      if (npre != 4 || nvalid != 16) $display("FAIL sole_pattern: got pre=%0d valid=%0d want pre=4 valid=16", npre, nvalid);
      else pass_cnt++;
      req_v[1] = 4'b0000;
   endtask

   task automatic test_async_reset();
      int waited;
      waited = 0;
      reset_all();
      req_v[0] = 4'b1111;
      @(negedge clk);
      while (!gv[0] && waited < 5) begin
         @(negedge clk);
         waited++;
      end
      total_cnt++;
      if (!gv[0]) $display("FAIL async_pre_grant: got valid=%b want 1 within 5 cycles", gv[0]);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      #2;
      rst_n_v[0] = 1'b0;
      #1;
      total_cnt++;
      if (act_out(0) !== 8'h00) $display("FAIL async_reset: got %b want %b", act_out(0), 8'h00);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (act_out(0) !== exp_out(0)) $display("FAIL async_held: got %b want %b", act_out(0), exp_out(0));
      else pass_cnt++;
      rst_n_v[0] = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (gv[0] !== 1'b1 || gid[0] !== 2'd0) $display("FAIL async_first_grant: got v=%b id=%0d want v=1 id=0", gv[0], gid[0]);
      else pass_cnt++;
      total_cnt++;
      if (act_out(0) !== exp_out(0)) $display("FAIL async_model: got %b want %b", act_out(0), exp_out(0));
      else pass_cnt++;
      req_v[0] = 4'b0000;
   endtask

   task automatic test_random();
      reset_all();
      for (int c = 1; c <= 400; c++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 3) == 0) req_v[k] = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (act_out(k) !== exp_out(k)) $display("FAIL random cyc%0d inst%0d: got %b want %b", c, k, act_out(k), exp_out(k));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] want_cnt;
      reset_all();
      req_v[2] = 4'b0011;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         total_cnt++;
         if (act_out(2) !== exp_out(2)) $display("FAIL saturate cyc%0d: got %b want %b", c, act_out(2), exp_out(2));
         else pass_cnt++;
      end
      want_cnt = (m[2].held > 32'd255) ? 8'd255 : m[2].held[7:0];
      total_cnt++;
      if (dut2.hold_cnt_q !== want_cnt) $display("FAIL saturate_cnt: got %0d want %0d", dut2.hold_cnt_q, want_cnt);
      else pass_cnt++;
      total_cnt++;
      if (gv[2] !== 1'b1 || gid[2] !== 2'd0) $display("FAIL saturate_holder: got v=%b id=%0d want v=1 id=0", gv[2], gid[2]);
      else pass_cnt++;
      req_v[2] = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_release();
      test_wrap();
      test_sole_timeout();
      test_async_reset();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
